gpu_rasterizer: RTL and testbench



---
 rtl/gpu_rasterizer_pkg.sv | 39 +++
 rtl/gpu_rect_walker.sv | 92 +++++++++
 rtl/gpu_rasterizer.sv | 145 ++++++++++++++
 tb/tb_gpu_rasterizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rasterizer_pkg.sv
// Shared types for the rasterizer: command op, sprite texel layout, pixel pipeline records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_rasterizer_pkg;

    localparam int GPU_FB_ADDR_W = 19;

    // One rasterizer command as stored in the CPU-filled op FIFO.
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] width;
        logic [10:0] height;
        logic        color;
        logic        mem_en;    // 1: sprite blit, 0: solid fill
        logic        scale;     // 1: 2x upscale of the sprite
        logic [15:0] mem_addr;
    } gpu_op_t;

    // Sprite ROM word layout.
    typedef struct packed {
        logic opaque;
        logic color;
    } sprite_texel_t;

    // Framebuffer write record; opaque doubles as the write request.
    typedef struct packed {
        logic [GPU_FB_ADDR_W-1:0] fb_addr;
        logic                     color;
        logic                     opaque;
    } gpu_pixel_t;

    // Sprite pixel waiting for its ROM word.
    typedef struct packed {
        logic                     vld;
        logic [GPU_FB_ADDR_W-1:0] fb_addr;
    } pipe_t;

endpackage

// File: rtl/gpu_rect_walker.sv
// Walks an op rectangle in raster order, producing fb/sprite addresses and an on-screen flag.
// Latency: combinational outputs from the current counter state; advances one pixel per step.
// Backpressure: none; the caller only asserts load/step on enabled cycles.
// Ports: load/x/y/width/height/scale/mem_addr capture an op; step advances one pixel;
//        pix_vld (on screen), pix_last, pix_fb_addr, pix_sprite_addr describe the current pixel.
module gpu_rect_walker
    import gpu_rasterizer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int FB_ADDR_WIDTH     = 19,
    parameter int SPRITE_ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [10:0]                  x,
    input  logic [10:0]                  y,
    input  logic [10:0]                  width,
    input  logic [10:0]                  height,
    input  logic                         scale,
    input  logic [SPRITE_ADDR_WIDTH-1:0] mem_addr,
    input  logic                         step,
    output logic                         pix_vld,
    output logic                         pix_last,
    output logic [FB_ADDR_WIDTH-1:0]     pix_fb_addr,
    output logic [SPRITE_ADDR_WIDTH-1:0] pix_sprite_addr
);

    localparam logic [11:0] HOR_LIM = 12'(HOR_ACTIVE_PIXELS);
    localparam logic [11:0] VER_LIM = 12'(VER_ACTIVE_PIXELS);

    logic [10:0]                  x_q, w_q, h_q, cx_q, cy_q;
    logic [11:0]                  y_q;
    logic                         scale_q;
    logic [FB_ADDR_WIDTH-1:0]     row_fb_q;   // (y + cy) * HOR_ACTIVE_PIXELS
    logic [SPRITE_ADDR_WIDTH-1:0] tex_row_q;  // mem_addr + ty * tex_w

    logic [11:0] px, py;
    logic [10:0] tex_w, tx;
    logic        row_last;

    // 12-bit sums so an 11-bit origin plus offset never wraps back on screen.
    assign px       = {1'b0, x_q} + {1'b0, cx_q};
    assign py       = y_q + {1'b0, cy_q};
    assign tex_w    = w_q >> scale_q;
    assign tx       = cx_q >> scale_q;
    assign row_last = (cx_q + 11'd1) == w_q;

    assign pix_vld         = (px < HOR_LIM) && (py < VER_LIM);
    assign pix_last        = row_last && ((cy_q + 11'd1) == h_q);
    assign pix_fb_addr     = row_fb_q + FB_ADDR_WIDTH'(px);
    assign pix_sprite_addr = tex_row_q + SPRITE_ADDR_WIDTH'(tx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            scale_q   <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            row_fb_q  <= '0;
            tex_row_q <= '0;
        end else if (load) begin
            x_q       <= x;
            y_q       <= {1'b0, y};
            w_q       <= width;
            h_q       <= height;
            scale_q   <= scale;
            cx_q      <= '0;
            cy_q      <= '0;
            // The only multiply: once per op, everything after is incremental.
            row_fb_q  <= FB_ADDR_WIDTH'(y * HOR_ACTIVE_PIXELS);
            tex_row_q <= mem_addr;
        end else if (step) begin
            if (row_last) begin
                cx_q     <= '0;
                cy_q     <= cy_q + 11'd1;
                row_fb_q <= row_fb_q + FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
                // ty = cy >> scale moves on every row at 1x, every odd row at 2x.
                if (!scale_q || cy_q[0]) begin
                    tex_row_q <= tex_row_q + SPRITE_ADDR_WIDTH'(tex_w);
                end
            end else begin
                cx_q <= cx_q + 11'd1;
            end
        end
    end

endmodule

// File: rtl/gpu_rasterizer.sv
// Pops ops from the command FIFO and rasterizes fills / sprite blits into the framebuffer.
// Latency: fill write 1 cycle after the pixel step, sprite write 2 cycles (ROM read + stage).
// Backpressure: ce=0 freezes all state; pops and writes are gated with ce so none repeat.
// Ports: op/op_rd_en/op_empty = FIFO read side (data valid the cycle after the pop);
//        sprite_addr/sprite_data = sprite ROM, 1-cycle read, assumed to share ce;
//        fb_wr_en/fb_addr/fb_data = framebuffer write; idle = nothing queued or pending.
module gpu_rasterizer
    import gpu_rasterizer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS),
    parameter int SPRITE_ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  gpu_op_t                      op,
    output logic                         op_rd_en,
    input  logic                         op_empty,
    output logic [SPRITE_ADDR_WIDTH-1:0] sprite_addr,
    input  logic [1:0]                   sprite_data,
    output logic                         fb_wr_en,
    output logic [FB_ADDR_WIDTH-1:0]     fb_addr,
    output logic                         fb_data,
    output logic                         idle
);

    typedef enum logic [1:0] {IDLE, LATCH, DRAW, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          rd_req, load, step;
    logic          color_q, mem_en_q;
    logic          pix_vld, pix_last;
    logic [FB_ADDR_WIDTH-1:0] pix_fb_addr;
    pipe_t         pipe_q;
    gpu_pixel_t    wr_q;
    sprite_texel_t texel;

    assign texel = sprite_texel_t'(sprite_data);

    gpu_rect_walker #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .FB_ADDR_WIDTH     (FB_ADDR_WIDTH),
        .SPRITE_ADDR_WIDTH (SPRITE_ADDR_WIDTH)
    ) u_walker (
        .clk             (clk),
        .rst             (rst),
        .load            (load & ce),
        .x               (op.x),
        .y               (op.y),
        .width           (op.width),
        .height          (op.height),
        .scale           (op.scale),
        .mem_addr        (SPRITE_ADDR_WIDTH'(op.mem_addr)),
        .step            (step & ce),
        .pix_vld         (pix_vld),
        .pix_last        (pix_last),
        .pix_fb_addr     (pix_fb_addr),
        .pix_sprite_addr (sprite_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!op_empty) begin
                    rd_req  = 1'b1;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                load    = 1'b1;
                state_d = (op.width == '0 || op.height == '0) ? IDLE : DRAW;
            end
            DRAW: begin
                step = 1'b1;
                if (pix_last) begin
                    state_d = mem_en_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_q  <= 1'b0;
            mem_en_q <= 1'b0;
        end else if (ce && load) begin
            color_q  <= op.color;
            mem_en_q <= op.mem_en;
        end
    end

    // Fill pixels go straight to the write register; sprite pixels wait one
    // stage in pipe_q for their ROM word. The two never overlap because a
    // sprite op drains pipe_q before returning to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
            wr_q   <= '0;
        end else if (ce) begin
            pipe_q.vld  <= 1'b0;
            wr_q.opaque <= 1'b0;
            if (step && !mem_en_q) begin
                wr_q.opaque  <= pix_vld;
                wr_q.fb_addr <= GPU_FB_ADDR_W'(pix_fb_addr);
                wr_q.color   <= color_q;
            end
            if (step && mem_en_q) begin
                pipe_q.vld     <= pix_vld;
                pipe_q.fb_addr <= GPU_FB_ADDR_W'(pix_fb_addr);
            end
            if (pipe_q.vld) begin
                wr_q.opaque  <= texel.opaque;
                wr_q.fb_addr <= pipe_q.fb_addr;
                wr_q.color   <= texel.color;
            end
        end
    end

    assign op_rd_en = rd_req & ce;
    assign fb_wr_en = wr_q.opaque & ce;
    assign fb_addr  = FB_ADDR_WIDTH'(wr_q.fb_addr);
    assign fb_data  = wr_q.color;
    // A write still held by ce=0 keeps idle low so frame swap waits for it.
    assign idle     = (state_q == IDLE) & op_empty & ~wr_q.opaque;

endmodule

// File: tb/tb_gpu_rasterizer.sv
module tb_gpu_rasterizer;
    import gpu_rasterizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b1;
    gpu_op_t     op  = '0;
    logic        op_rd_en;
    logic        op_empty = 1'b1;
    logic [15:0] sprite_addr;
    logic [1:0]  sprite_data = 2'b00;
    logic        fb_wr_en;
    logic [18:0] fb_addr;
    logic        fb_data;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit ce_rand = 1'b0;

    gpu_op_t     fifo_q[$];
    int          wr_addr_q[$];
    logic        wr_data_q[$];
    int          pop_q[$];
    logic [15:0] sa_trace [0:4095];
    logic [1:0]  rom [0:65535];

    gpu_rasterizer dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .op          (op),
        .op_rd_en    (op_rd_en),
        .op_empty    (op_empty),
        .sprite_addr (sprite_addr),
        .sprite_data (sprite_data),
        .fb_wr_en    (fb_wr_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read port: data registered on the pop.
    always @(posedge clk) begin
        if (op_rd_en && fifo_q.size() != 0) begin
            op_empty <= (fifo_q.size() == 1);
            op       <= fifo_q.pop_front();
        end
    end

    // Sprite ROM, 1-cycle read, clocked with ce.
    always @(posedge clk) begin
        if (ce) sprite_data <= rom[sprite_addr];
    end

    always @(posedge clk) begin
        #1;
        ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (fb_wr_en) begin
            wr_addr_q.push_back(int'(fb_addr));
            wr_data_q.push_back(fb_data);
        end
        if (op_rd_en) pop_q.push_back(cyc);
        sa_trace[cyc % 4096] = sprite_addr;
    end

    function automatic gpu_op_t mk(input int x, input int y, input int w, input int h,
                                   input bit c, input bit m, input bit s, input int a);
        gpu_op_t o;
        o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
        o.color = c; o.mem_en = m; o.scale = s; o.mem_addr = 16'(a);
        return o;
    endfunction

    task automatic push_op(input gpu_op_t o);
        fifo_q.push_back(o);
        op_empty = 1'b0;
    endtask

    task automatic start_test();
        @(posedge clk);
        #2;
        wr_addr_q.delete();
        wr_data_q.delete();
        pop_q.delete();
    endtask

    // Waits at negedges until idle; reports cycles spent and writes seen when idle rose.
    task automatic wait_idle(input int budget, output int n, output int w_at_idle);
        n = 0;
        @(negedge clk);
        while (!idle && n < budget) begin
            n++;
            @(negedge clk);
        end
        w_at_idle = wr_addr_q.size();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (op_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_op_rd_en got %b want 0", op_rd_en); end
        checks++; if (fb_wr_en !== 1'b0)  begin errors++; $display("FAIL rst_fb_wr_en got %b want 0", fb_wr_en); end
        checks++; if (fb_addr !== 19'd0)  begin errors++; $display("FAIL rst_fb_addr got %0d want 0", fb_addr); end
        checks++; if (fb_data !== 1'b0)   begin errors++; $display("FAIL rst_fb_data got %b want 0", fb_data); end
        checks++; if (sprite_addr !== 16'd0) begin errors++; $display("FAIL rst_sprite_addr got %0d want 0", sprite_addr); end
        checks++; if (idle !== 1'b1)      begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_rst_idle got %b want 1", idle); end
    endtask

    task automatic test_fill();
        int n, wi;
        int ea[8];
        ea = '{3210, 3211, 3212, 3213, 3850, 3851, 3852, 3853};
        start_test();
        push_op(mk(10, 5, 4, 2, 1'b1, 1'b0, 1'b0, 0));
        push_op(mk(0, 0, 0, 3, 1'b1, 1'b0, 1'b0, 0));
        wait_idle(200, n, wi);
        checks++; if (n >= 200) begin errors++; $display("FAIL fill_timeout cycles %0d limit 200", n); end
        checks++; if (pop_q.size() !== 2) begin errors++; $display("FAIL fill_pops got %0d want 2", pop_q.size()); end
        else begin
            checks++; if (pop_q[1] - pop_q[0] !== 10) begin errors++; $display("FAIL fill_op_cycles got %0d want 10", pop_q[1] - pop_q[0]); end
        end
        checks++; if (wr_addr_q.size() !== 8) begin errors++; $display("FAIL fill_writes got %0d want 8", wr_addr_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== 1'b1) begin
                errors++; $display("FAIL fill_px%0d got %0d/%b want %0d/1", i, wr_addr_q[i], wr_data_q[i], ea[i]);
            end
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fill_idle got %b want 1", idle); end
    endtask

    task automatic test_zero_size();
        int n, wi;
        start_test();
        push_op(mk(3, 3, 0, 5, 1'b1, 1'b0, 1'b0, 0));
        push_op(mk(0, 0, 1, 1, 1'b1, 1'b0, 1'b0, 0));
        wait_idle(100, n, wi);
        checks++; if (pop_q.size() !== 2) begin errors++; $display("FAIL zero_pops got %0d want 2", pop_q.size()); end
        else begin
            checks++; if (pop_q[1] - pop_q[0] !== 2) begin errors++; $display("FAIL zero_op_cycles got %0d want 2", pop_q[1] - pop_q[0]); end
        end
        checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL zero_writes got %0d want 1", wr_addr_q.size()); end
        else begin
            checks++; if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 1'b1) begin
                errors++; $display("FAIL zero_px got %0d/%b want 0/1", wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    task automatic test_clip();
        int n, wi;
        start_test();
        push_op(mk(638, 479, 4, 3, 1'b0, 1'b0, 1'b0, 0));
        push_op(mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 0));
        wait_idle(200, n, wi);
        checks++; if (pop_q.size() !== 2) begin errors++; $display("FAIL clip_pops got %0d want 2", pop_q.size()); end
        else begin
            checks++; if (pop_q[1] - pop_q[0] !== 14) begin errors++; $display("FAIL clip_op_cycles got %0d want 14", pop_q[1] - pop_q[0]); end
        end
        checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL clip_writes got %0d want 2", wr_addr_q.size()); end
        else begin
            checks++; if (wr_addr_q[0] !== 307198 || wr_data_q[0] !== 1'b0) begin
                errors++; $display("FAIL clip_px0 got %0d/%b want 307198/0", wr_addr_q[0], wr_data_q[0]);
            end
            checks++; if (wr_addr_q[1] !== 307199 || wr_data_q[1] !== 1'b0) begin
                errors++; $display("FAIL clip_px1 got %0d/%b want 307199/0", wr_addr_q[1], wr_data_q[1]);
            end
        end
    endtask

    task automatic test_sprite();
        int n, wi, t;
        int es[16];
        int ea[12];
        logic ed[12];
        es = '{100, 100, 101, 101, 100, 100, 101, 101, 102, 102, 103, 103, 102, 102, 103, 103};
        ea = '{6420, 6421, 6422, 6423, 7060, 7061, 7062, 7063, 7702, 7703, 8342, 8343};
        ed = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        start_test();
        push_op(mk(20, 10, 4, 4, 1'b0, 1'b1, 1'b1, 100));
        push_op(mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 0));
        wait_idle(200, n, wi);
        checks++; if (pop_q.size() !== 2) begin errors++; $display("FAIL spr_pops got %0d want 2", pop_q.size()); end
        else begin
            checks++; if (pop_q[1] - pop_q[0] !== 19) begin errors++; $display("FAIL spr_op_cycles got %0d want 19", pop_q[1] - pop_q[0]); end
            for (int i = 0; i < 16; i++) begin
                t = (pop_q[0] + 2 + i) % 4096;
                checks++; if (sa_trace[t] !== 16'(es[i])) begin
                    errors++; $display("FAIL spr_addr%0d got %0d want %0d", i, sa_trace[t], es[i]);
                end
            end
        end
        checks++; if (wr_addr_q.size() !== 12) begin errors++; $display("FAIL spr_writes got %0d want 12", wr_addr_q.size()); end
        else for (int i = 0; i < 12; i++) begin
            checks++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                errors++; $display("FAIL spr_px%0d got %0d/%b want %0d/%b", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_back_to_back_ce();
        int n, wi;
        int ea[11];
        logic ed[11];
        ea = '{64100, 64101, 64102, 64740, 64741, 64742, 0, 1, 641, 645, 646};
        ed = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        start_test();
        ce_rand = 1'b1;
        push_op(mk(100, 100, 3, 2, 1'b1, 1'b0, 1'b0, 0));
        push_op(mk(0, 0, 2, 2, 1'b0, 1'b1, 1'b0, 100));
        push_op(mk(5, 1, 2, 1, 1'b0, 1'b0, 1'b0, 0));
        wait_idle(1000, n, wi);
        ce_rand = 1'b0;
        checks++; if (n >= 1000) begin errors++; $display("FAIL ce_timeout cycles %0d limit 1000", n); end
        checks++; if (pop_q.size() !== 3) begin errors++; $display("FAIL ce_pops got %0d want 3", pop_q.size()); end
        checks++; if (wi !== 11) begin errors++; $display("FAIL ce_idle_early writes %0d at idle want 11", wi); end
        checks++; if (wr_addr_q.size() !== 11) begin errors++; $display("FAIL ce_writes got %0d want 11", wr_addr_q.size()); end
        else for (int i = 0; i < 11; i++) begin
            checks++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                errors++; $display("FAIL ce_px%0d got %0d/%b want %0d/%b", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        int wc, pc;
        start_test();
        push_op(mk(0, 0, 100, 100, 1'b1, 1'b0, 1'b0, 0));
        repeat (30) @(negedge clk);
        checks++; if (fb_wr_en !== 1'b1) begin errors++; $display("FAIL mid_drawing got %b want 1", fb_wr_en); end
        #2 rst = 1'b0;
        #1;
        checks++; if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL mid_abort_wr got %b want 0", fb_wr_en); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        wc = wr_addr_q.size();
        pc = pop_q.size();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %b want 1", idle); end
        repeat (50) @(negedge clk);
        checks++; if (wr_addr_q.size() !== wc) begin errors++; $display("FAIL mid_no_writes got %0d want %0d", wr_addr_q.size(), wc); end
        checks++; if (pop_q.size() !== pc || pc !== 1) begin errors++; $display("FAIL mid_no_retry pops %0d want 1", pop_q.size()); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle_hold got %b want 1", idle); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 2'b00;
        rom[100] = 2'b11;
        rom[101] = 2'b10;
        rom[102] = 2'b01;
        rom[103] = 2'b11;
        test_reset();
        test_fill();
        test_zero_size();
        test_clip();
        test_sprite();
        test_back_to_back_ce();
        test_reset_mid_draw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
